// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants and modular-arithmetic helpers for the NTT blocks.
//   BFLY_CT / BFLY_GS : butterfly mode encodings (mode_i values)
//   mod_bits          : bit length of a modulus
//   barrett_mu        : floor(2^(2k) / m) for a k-bit modulus m, built without '/'
//   mod_add / mod_sub : (a +/- t) mod m for operands < m
//   mod_half          : x * 2^-1 mod m for odd m
// All helpers work on MAX_W-bit words. Narrower callers zero-extend their
// operands and truncate the result back to their width.
package ntt_pkg;

  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] word_t;

  localparam logic BFLY_CT = 1'b0;  // Cooley-Tukey, DIT, forward
  localparam logic BFLY_GS = 1'b1;  // Gentleman-Sande, DIF, inverse

  function automatic int mod_bits(input word_t m);
    int n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (m[i]) n = i + 1;
    end
    return n;
  endfunction

  // Restoring long division of 2^(2k) by m. The remainder stays below m,
  // so one spare bit above MAX_W+1 is enough. For odd m with bit length k
  // the quotient is below 2^(k+1), so it fits MAX_W+1 bits.
  function automatic logic [MAX_W:0] barrett_mu(input int k, input word_t m);
    logic [MAX_W+1:0] rem;
    logic [MAX_W:0]   q;
    rem = '0;
    q   = '0;
    for (int i = 2 * MAX_W; i >= 0; i--) begin
      rem = {rem[MAX_W:0], (i == 2 * k)};
      if (rem >= {2'b00, m}) begin
        rem = rem - {2'b00, m};
        if (i <= MAX_W) q[i] = 1'b1;
      end
    end
    return q;
  endfunction

  function automatic word_t mod_add(input word_t a, input word_t t, input word_t m);
    logic [MAX_W:0] s;
    s = {1'b0, a} + {1'b0, t};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[MAX_W-1:0];
  endfunction

  function automatic word_t mod_sub(input word_t a, input word_t t, input word_t m);
    logic [MAX_W:0] d;
    if (a < t) d = {1'b0, a} + {1'b0, m} - {1'b0, t};
    else       d = {1'b0, a} - {1'b0, t};
    return d[MAX_W-1:0];
  endfunction

  // Odd x: x+m is even, so (x+m)/2 is exact and still below m.
  function automatic word_t mod_half(input word_t x, input word_t m);
    logic [MAX_W:0] s;
    if (x[0]) s = {1'b0, x} + {1'b0, m};
    else      s = {1'b0, x};
    return s[MAX_W:1];
  endfunction

endpackage

// File: rtl/ntt_modmul.sv
// ntt_modmul: pipelined (x * y) mod MODULUS using Barrett reduction.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : stage enable; every register holds when low
//   x_i, y_i   : operands, < MODULUS
//   r_o        : (x_i * y_i) mod MODULUS, STAGES enabled cycles later
// Register placement: product | quotient estimate | reduced result, with
// extra delay registers appended when STAGES > 3. Fewer stages merge phases.
// The Barrett shifts use the bit length k of MODULUS (k == WIDTH when the
// modulus fills the word). The estimate is then at most 2 below the true
// quotient, so two conditional subtracts finish the reduction.
module ntt_modmul
  import ntt_pkg::*;
#(
  parameter int              WIDTH   = 64,
  parameter logic [WIDTH-1:0] MODULUS = 64'hFFFFFFFF00000001,
  parameter int              STAGES  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] r_o
);

  localparam int K   = mod_bits(word_t'(MODULUS));
  localparam int PW  = 2 * WIDTH;   // full product width
  localparam int QW  = K + 2;       // x >> (K-1) < 2^(K+1)
  localparam int MUW = K + 1;
  localparam int PQW = QW + MUW;
  localparam int RW  = WIDTH + 2;   // x - q*M < 3*M
  localparam logic [MUW-1:0] MU = MUW'(barrett_mu(K, word_t'(MODULUS)));

  function automatic logic [QW-1:0] est_q(input logic [PW-1:0] x);
    logic [PW-1:0]  xs;
    logic [PQW-1:0] p;
    xs = x >> (K - 1);
    p  = PQW'(xs[QW-1:0]) * PQW'(MU);
    p  = p >> (K + 1);
    return p[QW-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] reduce(input logic [PW-1:0] x, input logic [QW-1:0] q);
    logic [PW-1:0] qm;
    logic [PW-1:0] d;
    logic [RW-1:0] r;
    logic [RW-1:0] mr;
    qm = PW'(q) * PW'(MODULUS);
    d  = x - qm;
    r  = d[RW-1:0];
    mr = RW'(MODULUS);
    if (r >= mr) r = r - mr;
    if (r >= mr) r = r - mr;
    return r[WIDTH-1:0];
  endfunction

  logic [PW-1:0] x_c;
  assign x_c = PW'(x_i) * PW'(y_i);

  generate
    if (STAGES == 1) begin : g_s1
      logic [WIDTH-1:0] r1;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  r1 <= '0;
        else if (en) r1 <= reduce(x_c, est_q(x_c));
      end
      assign r_o = r1;
    end else if (STAGES == 2) begin : g_s2
      logic [PW-1:0]    x1;
      logic [WIDTH-1:0] r2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x1 <= '0;
          r2 <= '0;
        end else if (en) begin
          x1 <= x_c;
          r2 <= reduce(x1, est_q(x1));
        end
      end
      assign r_o = r2;
    end else begin : g_s3
      logic [PW-1:0]    x1;
      logic [PW-1:0]    x2;
      logic [QW-1:0]    q2;
      logic [WIDTH-1:0] r3;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x1 <= '0;
          x2 <= '0;
          q2 <= '0;
          r3 <= '0;
        end else if (en) begin
          x1 <= x_c;
          x2 <= x1;
          q2 <= est_q(x1);
          r3 <= reduce(x2, q2);
        end
      end
      if (STAGES > 3) begin : g_tail
        logic [WIDTH-1:0] tail [STAGES-3];
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int i = 0; i < STAGES - 3; i++) tail[i] <= '0;
          end else if (en) begin
            tail[0] <= r3;
            for (int i = 1; i < STAGES - 3; i++) tail[i] <= tail[i-1];
          end
        end
        assign r_o = tail[STAGES-4];
      end else begin : g_notail
        assign r_o = r3;
      end
    end
  endgenerate

endmodule

// File: rtl/ntt_butterfly_pipe.sv
// ntt_butterfly_pipe: pipelined, stallable radix-2 NTT butterfly.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input beat handshake
//   mode_i               : BFLY_CT (0) or BFLY_GS (1), sampled per beat
//   a_i, b_i, w_i        : upper operand, lower operand, twiddle (all < MODULUS)
//   tag_i / tag_o        : sideband tag, passed through with its beat
//   scale_i              : only with NTT_BFLY_INV_SCALE_EN; halves both GS results
//   out_valid/out_ready  : output beat handshake
//   out_a, out_b         : butterfly results
// Optional feature macro: NTT_BFLY_INV_SCALE_EN.
// Pipeline: S0 (GS pre-add/sub) -> ntt_modmul (MUL_STAGES) -> final add/sub.
// Beat latency is MUL_STAGES+2 cycles from the cycle of the handshake.
//
// Handshake: a beat moves on a rising edge where valid && ready. The source
// holds the beat stable while valid && !ready. The whole pipeline shares one
// enable, adv = out_ready || !out_valid, and in_ready = adv, so a stall
// freezes every stage (bubbles included) and nothing is dropped or reordered.
module ntt_butterfly_pipe
  import ntt_pkg::*;
#(
  parameter int               WIDTH      = 64,
  parameter logic [WIDTH-1:0] MODULUS    = 64'hFFFFFFFF00000001,
  parameter int               MUL_STAGES = 3,
  parameter int               TAG_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] w_i,
  input  logic [TAG_W-1:0] tag_i,
`ifdef NTT_BFLY_INV_SCALE_EN
  input  logic             scale_i,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [TAG_W-1:0] tag_o
);

  localparam word_t MOD_W = word_t'(MODULUS);
  localparam int    LAST  = MUL_STAGES - 1;

  logic adv;
  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  // S0: GS forms a+b (partner) and a-b (multiplicand); CT passes a and b.
  logic [WIDTH-1:0] gs_sum, gs_diff;
  assign gs_sum  = WIDTH'(mod_add(word_t'(a_i), word_t'(b_i), MOD_W));
  assign gs_diff = WIDTH'(mod_sub(word_t'(a_i), word_t'(b_i), MOD_W));

  logic             s0_valid, s0_mode;
  logic [TAG_W-1:0] s0_tag;
  logic [WIDTH-1:0] s0_p, s0_x, s0_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_mode  <= BFLY_CT;
      s0_tag   <= '0;
      s0_p     <= '0;
      s0_x     <= '0;
      s0_w     <= '0;
    end else if (adv) begin
      s0_valid <= in_valid;
      s0_mode  <= mode_i;
      s0_tag   <= tag_i;
      s0_p     <= (mode_i == BFLY_GS) ? gs_sum : a_i;
      s0_x     <= (mode_i == BFLY_GS) ? gs_diff : b_i;
      s0_w     <= w_i;
    end
  end

  logic [WIDTH-1:0] mm_r;

  ntt_modmul #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .STAGES  (MUL_STAGES)
  ) u_modmul (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .x_i   (s0_x),
    .y_i   (s0_w),
    .r_o   (mm_r)
  );

  // Sideband delay lines, matched to the multiplier depth.
  logic             dl_valid [MUL_STAGES];
  logic             dl_mode  [MUL_STAGES];
  logic [TAG_W-1:0] dl_tag   [MUL_STAGES];
  logic [WIDTH-1:0] dl_p     [MUL_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_STAGES; i++) begin
        dl_valid[i] <= 1'b0;
        dl_mode[i]  <= BFLY_CT;
        dl_tag[i]   <= '0;
        dl_p[i]     <= '0;
      end
    end else if (adv) begin
      dl_valid[0] <= s0_valid;
      dl_mode[0]  <= s0_mode;
      dl_tag[0]   <= s0_tag;
      dl_p[0]     <= s0_p;
      for (int i = 1; i < MUL_STAGES; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_mode[i]  <= dl_mode[i-1];
        dl_tag[i]   <= dl_tag[i-1];
        dl_p[i]     <= dl_p[i-1];
      end
    end
  end

`ifdef NTT_BFLY_INV_SCALE_EN
  logic s0_scale;
  logic dl_scale [MUL_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_scale <= 1'b0;
      for (int i = 0; i < MUL_STAGES; i++) dl_scale[i] <= 1'b0;
    end else if (adv) begin
      s0_scale    <= scale_i;
      dl_scale[0] <= s0_scale;
      for (int i = 1; i < MUL_STAGES; i++) dl_scale[i] <= dl_scale[i-1];
    end
  end
`endif

  // Final stage: CT butterfly add/sub; GS results are already complete.
  logic [WIDTH-1:0] fin_a, fin_b;

  always_comb begin
    fin_a = '0;
    fin_b = '0;
    if (dl_mode[LAST] == BFLY_CT) begin
      fin_a = WIDTH'(mod_add(word_t'(dl_p[LAST]), word_t'(mm_r), MOD_W));
      fin_b = WIDTH'(mod_sub(word_t'(dl_p[LAST]), word_t'(mm_r), MOD_W));
    end else begin
      fin_a = dl_p[LAST];
      fin_b = mm_r;
`ifdef NTT_BFLY_INV_SCALE_EN
      if (dl_scale[LAST]) begin
        fin_a = WIDTH'(mod_half(word_t'(dl_p[LAST]), MOD_W));
        fin_b = WIDTH'(mod_half(word_t'(mm_r), MOD_W));
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      tag_o     <= '0;
    end else if (adv) begin
      out_valid <= dl_valid[LAST];
      out_a     <= fin_a;
      out_b     <= fin_b;
      tag_o     <= dl_tag[LAST];
    end
  end

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// Bench for ntt_butterfly_pipe: a small instance (WIDTH=8, M=17, 3 mul
// stages) for directed vectors, stall and reset, plus a default-parameter
// instance for the 64-bit corner vector and a random stream. Define
// NTT_BFLY_INV_SCALE_EN for the whole build to cover the scale port.
module tb_ntt_butterfly_pipe;

  localparam logic [63:0] DM = 64'hFFFFFFFF00000001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- small instance ----------------
  logic       in_valid = 1'b0, in_ready, mode = 1'b0;
  logic [7:0] a = '0, b = '0, w = '0, tag = '0;
  logic       out_valid, out_ready = 1'b1;
  logic [7:0] out_a, out_b, tag_o;
`ifdef NTT_BFLY_INV_SCALE_EN
  logic       scale = 1'b0;
`endif

  ntt_butterfly_pipe #(
    .WIDTH(8), .MODULUS(8'd17), .MUL_STAGES(3), .TAG_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .mode_i(mode),
    .a_i(a), .b_i(b), .w_i(w), .tag_i(tag),
`ifdef NTT_BFLY_INV_SCALE_EN
    .scale_i(scale),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .tag_o(tag_o)
  );

  // ---------------- default-parameter instance ----------------
  logic        d_in_valid = 1'b0, d_in_ready, d_mode = 1'b0;
  logic [63:0] d_a = '0, d_b = '0, d_w = '0;
  logic [7:0]  d_tag = '0;
  logic        d_out_valid, d_out_ready = 1'b1;
  logic [63:0] d_out_a, d_out_b;
  logic [7:0]  d_tag_o;
`ifdef NTT_BFLY_INV_SCALE_EN
  logic        d_scale = 1'b0;
`endif

  ntt_butterfly_pipe dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .mode_i(d_mode),
    .a_i(d_a), .b_i(d_b), .w_i(d_w), .tag_i(d_tag),
`ifdef NTT_BFLY_INV_SCALE_EN
    .scale_i(d_scale),
`endif
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_a(d_out_a), .out_b(d_out_b), .tag_o(d_tag_o)
  );

  // ---------------- checking ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  // Reference butterfly built on the '%' operator.
  function automatic logic [63:0] mulmod(input logic [63:0] x, input logic [63:0] y,
                                         input logic [63:0] m);
    logic [127:0] p;
    p = ({64'd0, x} * {64'd0, y}) % {64'd0, m};
    return p[63:0];
  endfunction

  function automatic logic [127:0] gold(input logic md, input logic [63:0] ga,
                                        input logic [63:0] gb, input logic [63:0] gw,
                                        input logic [63:0] m);
    logic [64:0] s, d;
    logic [63:0] t;
    if (!md) begin
      t = mulmod(gb, gw, m);
      s = ({1'b0, ga} + {1'b0, t}) % {1'b0, m};
      d = ({1'b0, ga} + {1'b0, m} - {1'b0, t}) % {1'b0, m};
      return {s[63:0], d[63:0]};
    end
    s = ({1'b0, ga} + {1'b0, gb}) % {1'b0, m};
    d = ({1'b0, ga} + {1'b0, m} - {1'b0, gb}) % {1'b0, m};
    t = mulmod(d[63:0], gw, m);
    return {s[63:0], t};
  endfunction

  // Scoreboards: {tag, out_a, out_b}
  logic [23:0]  exp_q[$];
  logic [135:0] exp64_q[$];
  logic [23:0]  e8;
  logic [135:0] e64;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 64'(out_valid), 64'd0);
      else begin
        e8 = exp_q.pop_front();
        check("out_a", 64'(out_a), 64'(e8[15:8]));
        check("out_b", 64'(out_b), 64'(e8[7:0]));
        check("tag_o", 64'(tag_o), 64'(e8[23:16]));
      end
    end
  end

  always @(negedge clk) begin
    if (d_out_valid && d_out_ready) begin
      if (exp64_q.size() == 0) check("d_unexpected_out", 64'(d_out_valid), 64'd0);
      else begin
        e64 = exp64_q.pop_front();
        check("d_out_a", d_out_a, e64[127:64]);
        check("d_out_b", d_out_b, e64[63:0]);
        check("d_tag_o", 64'(d_tag_o), 64'(e64[135:128]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One beat into the idle small pipe; checks latency to out_valid.
  task automatic send_one(input string name, input logic m, input logic [7:0] ia,
                          input logic [7:0] ib, input logic [7:0] iw, input logic [7:0] itag,
                          input logic [7:0] ea, input logic [7:0] eb);
    int lat;
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    mode = m; a = ia; b = ib; w = iw; tag = itag; in_valid = 1'b1;
    exp_q.push_back({itag, ea, eb});
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd5);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic d_send_one(input string name, input logic m, input logic [63:0] ia,
                            input logic [63:0] ib, input logic [63:0] iw,
                            input logic [7:0] itag, input logic [63:0] ea,
                            input logic [63:0] eb);
    int lat;
    d_mode = m; d_a = ia; d_b = ib; d_w = iw; d_tag = itag; d_in_valid = 1'b1;
    exp64_q.push_back({itag, ea, eb});
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    lat = 1;
    while (!d_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd5);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int          cyc, idx, sent;
    logic        acc, prev_stall, saw;
    logic [7:0]  h_a, h_b, h_t;
    logic [7:0]  ba, bb, bw;
    logic [127:0] g;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_a", 64'(out_a), 64'd0);
    check("rst_out_b", 64'(out_b), 64'd0);
    check("rst_tag_o", 64'(tag_o), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed butterflies
    send_one("ct_basic", 1'b0, 8'd3, 8'd5, 8'd4, 8'h11, 8'd6, 8'd0);
    send_one("gs_basic", 1'b1, 8'd3, 8'd5, 8'd4, 8'h22, 8'd8, 8'd9);
    send_one("ct_wrap", 1'b0, 8'd16, 8'd1, 8'd1, 8'h33, 8'd0, 8'd15);
    send_one("gs_wrap", 1'b1, 8'd0, 8'd16, 8'd1, 8'h44, 8'd16, 8'd1);
`ifdef NTT_BFLY_INV_SCALE_EN
    scale = 1'b1;
    send_one("gs_scale", 1'b1, 8'd3, 8'd5, 8'd4, 8'h55, 8'd4, 8'd13);
    send_one("ct_scale_ignored", 1'b0, 8'd3, 8'd5, 8'd4, 8'h66, 8'd6, 8'd0);
    scale = 1'b0;
`endif

    // Stall: 10 back-to-back beats, out_ready low in cycles 6..8
    idx = 0; cyc = 0; prev_stall = 1'b0;
    h_a = '0; h_b = '0; h_t = '0;
    while ((idx < 10 || exp_q.size() > 0) && cyc < 60) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      if (idx < 10) begin
        ba = 8'((idx * 5 + 3) % 17);
        bb = 8'((idx * 7 + 1) % 17);
        bw = 8'((idx + 2) % 17);
        mode = idx[0]; a = ba; b = bb; w = bw; tag = 8'(idx);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), (cyc >= 6 && cyc <= 8) ? 64'd0 : 64'd1);
      if (prev_stall) begin
        check("hold_out_a", 64'(out_a), 64'(h_a));
        check("hold_out_b", 64'(out_b), 64'(h_b));
        check("hold_tag_o", 64'(tag_o), 64'(h_t));
      end
      prev_stall = out_valid && !out_ready;
      h_a = out_a; h_b = out_b; h_t = tag_o;
      acc = in_valid && in_ready;
      if (acc) begin
        g = gold(mode, 64'(a), 64'(b), 64'(w), 64'd17);
        exp_q.push_back({tag, g[71:64], g[7:0]});
      end
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("burst_drain", 64'(exp_q.size()), 64'd0);
    check("burst_sent", 64'(idx), 64'd10);

    // Reset with 4 beats in flight: they must never appear
    for (int i = 0; i < 4; i++) begin
      mode = 1'b0; a = 8'(i + 1); b = 8'd2; w = 8'd3; tag = 8'(8'hA0 + i);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_a", 64'(out_a), 64'd0);
    check("mid_rst_out_b", 64'(out_b), 64'd0);
    check("mid_rst_tag_o", 64'(tag_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("no_out_after_rst", 64'(saw), 64'd0);
    @(posedge clk); #1;
    send_one("post_rst", 1'b0, 8'd3, 8'd5, 8'd4, 8'h77, 8'd6, 8'd0);

    // Default parameters: corner vector then a random stream
    d_send_one("d_ct_corner", 1'b0, 64'd0, DM - 64'd1, DM - 64'd1, 8'h5A, 64'd1, DM - 64'd1);

    sent = 0; cyc = 0;
    while ((sent < 400 || exp64_q.size() > 0) && cyc < 5000) begin
      d_out_ready = ($urandom_range(0, 3) != 0);
      if (!d_in_valid && sent < 400 && $urandom_range(0, 4) != 0) begin
        d_mode = 1'($urandom_range(0, 1));
        d_a = {$urandom, $urandom}; if (d_a >= DM) d_a = d_a - DM;
        d_b = {$urandom, $urandom}; if (d_b >= DM) d_b = d_b - DM;
        d_w = {$urandom, $urandom}; if (d_w >= DM) d_w = d_w - DM;
        d_tag = 8'(sent);
        d_in_valid = 1'b1;
      end
      @(negedge clk);
      acc = d_in_valid && d_in_ready;
      if (acc) begin
        g = gold(d_mode, d_a, d_b, d_w, DM);
        exp64_q.push_back({d_tag, g});
      end
      @(posedge clk); #1;
      if (acc) begin
        d_in_valid = 1'b0;
        sent++;
      end
      cyc++;
    end
    d_out_ready = 1'b1;
    check("d_random_drain", 64'(exp64_q.size()), 64'd0);
    check("d_random_sent", 64'(sent), 64'd400);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
